// File: rtl/rv_pkg.sv
// Shared RV32I encodings and LSU types for the load/store unit.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

  // Width encoding not supported for the given access direction.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else          return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  // Halfword needs addr[0]==0, word needs addr[1:0]==0.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/gnt/rvalid port of the load/store unit.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_store_unit_align.sv
// Store byte-lane/enable generation and load extract/extend (combinational).
module lsu_align
  import rv_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_f3,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store lanes: replicate data across lanes, enable only the addressed bytes.
  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    case (i_f3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
      end
      2'b10: begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
      end
      default: ;
    endcase
  end

  // Load extract: pick the addressed byte/half and extend per funct3.
  always_comb begin
    w_byte = '0;
    case (i_addr_lo)
      2'd0: w_byte = i_load_word[7:0];
      2'd1: w_byte = i_load_word[15:8];
      2'd2: w_byte = i_load_word[23:16];
      2'd3: w_byte = i_load_word[31:24];
      default: ;
    endcase
    w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
    case (i_f3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_load_data = i_load_word;
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM stage: drives the data-memory port, aligns stores, extends loads and
// produces one registered writeback or exception pulse per instruction.
module load_store_unit
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [6:0]                opcode,
  input  logic [2:0]                funct3,
  input  logic [4:0]                rd,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               store_data,
  output logic                      lsu_stall,
  load_store_unit_if.master         dmem,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic [31:0]               wb_data,
  output logic                      exc,
  output logic [1:0]                exc_code
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state, w_state_nxt;
  logic [31:0] r_addr, r_sdata;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_we;
  logic [CW-1:0] r_cnt;

  logic        w_is_mem, w_is_store, w_illegal, w_misalign, w_accept, w_timeout;
  logic        w_wb_valid_nxt, w_exc_nxt;
  logic [4:0]  w_wb_rd_nxt;
  logic [31:0] w_wb_data_nxt, w_load_data, w_wdata;
  logic [1:0]  w_exc_code_nxt;
  logic [3:0]  w_be;

  assign w_is_store = (opcode == OP_STORE);
  assign w_is_mem   = ex_valid && (opcode == OP_LOAD || w_is_store);
  assign w_illegal  = f3_illegal(w_is_store, funct3);
  assign w_misalign = addr_misaligned(funct3, alu_result[1:0]);
  assign w_accept   = (r_state == ST_IDLE) && w_is_mem && !w_illegal && !w_misalign;
  assign w_timeout  = (r_cnt == LAST);
  assign lsu_stall  = (r_state != ST_IDLE);

  lsu_align u_align (
    .i_addr_lo    (r_addr[1:0]),
    .i_f3         (r_f3),
    .i_store_data (r_sdata),
    .i_load_word  (dmem.rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // State register, access latches, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_sdata  <= '0;
      r_f3     <= '0;
      r_rd     <= '0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      exc      <= 1'b0;
      exc_code <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_is_mem) begin
        r_addr  <= alu_result;
        r_sdata <= store_data;
        r_f3    <= funct3;
        r_rd    <= rd;
        r_we    <= w_is_store;
      end
      if (w_accept)                r_cnt <= '0;
      else if (r_state != ST_IDLE) r_cnt <= r_cnt + CW'(1);
      wb_valid <= w_wb_valid_nxt;
      wb_rd    <= w_wb_rd_nxt;
      wb_data  <= w_wb_data_nxt;
      exc      <= w_exc_nxt;
      exc_code <= w_exc_code_nxt;
    end
  end

  // Next-state: a completed handshake takes priority over a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (dmem.gnt)       w_state_nxt = r_we ? ST_IDLE : ST_WAIT;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_WAIT: if (dmem.rvalid || w_timeout) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: bus drive from state, next-cycle writeback/exception values.
  always_comb begin
    w_wb_valid_nxt = 1'b0;
    w_wb_rd_nxt    = '0;
    w_wb_data_nxt  = '0;
    w_exc_nxt      = 1'b0;
    w_exc_code_nxt = '0;
    dmem.req   = (r_state == ST_REQ);
    dmem.we    = dmem.req && r_we;
    dmem.addr  = dmem.req ? {r_addr[31:2], 2'b00} : '0;
    dmem.be    = dmem.req ? w_be : '0;
    dmem.wdata = (dmem.req && r_we) ? w_wdata : '0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mem) begin
          if (w_illegal) begin
            w_exc_nxt      = 1'b1;
            w_exc_code_nxt = EXC_ILLEGAL;
          end else if (w_misalign) begin
            w_exc_nxt      = 1'b1;
            w_exc_code_nxt = EXC_MISALIGN;
          end
        end else if (ex_valid && opcode != OP_BRANCH) begin
          w_wb_valid_nxt = 1'b1;
          w_wb_rd_nxt    = rd;
          w_wb_data_nxt  = alu_result;
        end
      end
      ST_REQ: begin
        if (!dmem.gnt && w_timeout) begin
          w_exc_nxt      = 1'b1;
          w_exc_code_nxt = EXC_TIMEOUT;
        end
      end
      ST_WAIT: begin
        if (dmem.rvalid) begin
          w_wb_valid_nxt = 1'b1;
          w_wb_rd_nxt    = r_rd;
          w_wb_data_nxt  = w_load_data;
        end else if (w_timeout) begin
          w_exc_nxt      = 1'b1;
          w_exc_code_nxt = EXC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result, store_data;
  logic        lsu_stall, wb_valid, exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  exc_code;

  int n_assert = 0;
  int n_fail   = 0;

  load_store_unit_if dmem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .opcode     (opcode),
    .funct3     (funct3),
    .rd         (rd),
    .alu_result (alu_result),
    .store_data (store_data),
    .lsu_stall  (lsu_stall),
    .dmem       (dmem_bus.master),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .exc        (exc),
    .exc_code   (exc_code)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; returns just after the accepting edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1; opcode = op; funct3 = f3; rd = r; alu_result = a; store_data = d;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; opcode = '0; funct3 = '0; rd = '0;
    alu_result = '0; store_data = '0;
    dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = '0;
    tick(); tick();
    check("rst_req",   32'(dmem_bus.req), 32'd0);
    check("rst_stall", 32'(lsu_stall),    32'd0);
    check("rst_wb",    32'(wb_valid),     32'd0);
    check("rst_exc",   32'(exc),          32'd0);
    check("rst_addr",  dmem_bus.addr,     32'd0);
    rst = 1'b0;
    tick();

    // ADD pass-through
    issue(OP_ADD, 3'b000, 5'd3, 32'd15, 32'd0);
    check("add_wbv",  32'(wb_valid),     32'd1);
    check("add_rd",   32'(wb_rd),        32'd3);
    check("add_data", wb_data,           32'd15);
    check("add_req",  32'(dmem_bus.req), 32'd0);
    // BRANCH produces nothing
    issue(OP_BR, 3'b000, 5'd4, 32'd99, 32'd0);
    check("br_wbv",   32'(wb_valid),     32'd0);

    // LW 112: gnt in first REQ cycle, rvalid next cycle
    issue(OP_LD, 3'b010, 5'd7, 32'd112, 32'd0);
    check("lw_req",   32'(dmem_bus.req), 32'd1);
    check("lw_we",    32'(dmem_bus.we),  32'd0);
    check("lw_addr",  dmem_bus.addr,     32'd112);
    check("lw_be",    32'(dmem_bus.be),  32'hF);
    check("lw_stall1",32'(lsu_stall),    32'd1);
    dmem_bus.gnt = 1'b1;
    tick();
    dmem_bus.gnt = 1'b0;
    check("lw_req_w", 32'(dmem_bus.req), 32'd0);
    check("lw_stall2",32'(lsu_stall),    32'd1);
    check("lw_wb_early", 32'(wb_valid),  32'd0);
    dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'hDEADBEEF;
    tick();
    dmem_bus.rvalid = 1'b0;
    check("lw_wbv",   32'(wb_valid),     32'd1);
    check("lw_rd",    32'(wb_rd),        32'd7);
    check("lw_data",  wb_data,           32'hDEADBEEF);
    check("lw_stall3",32'(lsu_stall),    32'd0);
    tick();
    check("lw_wb_pulse", 32'(wb_valid),  32'd0);

    // LB / LBU / LH on 0x80FF7F00
    issue(OP_LD, 3'b000, 5'd8, 32'h67, 32'd0);
    check("lb_addr",  dmem_bus.addr,     32'h64);
    check("lb_be",    32'(dmem_bus.be),  32'b1000);
    dmem_bus.gnt = 1'b1; tick(); dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h80FF7F00; tick(); dmem_bus.rvalid = 1'b0;
    check("lb_data",  wb_data,           32'hFFFFFF80);
    issue(OP_LD, 3'b100, 5'd9, 32'h67, 32'd0);
    dmem_bus.gnt = 1'b1; tick(); dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b1; tick(); dmem_bus.rvalid = 1'b0;
    check("lbu_data", wb_data,           32'h00000080);
    issue(OP_LD, 3'b001, 5'd10, 32'h66, 32'd0);
    dmem_bus.gnt = 1'b1; tick(); dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b1; tick(); dmem_bus.rvalid = 1'b0;
    check("lh_data",  wb_data,           32'hFFFF80FF);
    issue(OP_LD, 3'b101, 5'd10, 32'h64, 32'd0);
    dmem_bus.gnt = 1'b1; tick(); dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b1; tick(); dmem_bus.rvalid = 1'b0;
    check("lhu_data", wb_data,           32'h00007F00);

    // SB 0x101 with gnt delayed 3 cycles
    issue(OP_ST, 3'b000, 5'd1, 32'h101, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      check("sb_req_hold", 32'(dmem_bus.req), 32'd1);
      check("sb_be",    32'(dmem_bus.be),  32'b0010);
      check("sb_wdata", dmem_bus.wdata,    32'h78787878);
      check("sb_addr",  dmem_bus.addr,     32'h100);
      tick();
    end
    check("sb_req4",  32'(dmem_bus.req), 32'd1);
    check("sb_we",    32'(dmem_bus.we),  32'd1);
    dmem_bus.gnt = 1'b1; tick(); dmem_bus.gnt = 1'b0;
    check("sb_idle",  32'(lsu_stall),    32'd0);
    check("sb_req_off", 32'(dmem_bus.req), 32'd0);
    check("sb_wbv",   32'(wb_valid),     32'd0);
    // SH upper half, immediate gnt
    issue(OP_ST, 3'b001, 5'd1, 32'h102, 32'hAAAA5678);
    check("sh_be",    32'(dmem_bus.be),  32'b1100);
    check("sh_wdata", dmem_bus.wdata,    32'h56785678);
    dmem_bus.gnt = 1'b1; tick(); dmem_bus.gnt = 1'b0;
    check("sh_idle",  32'(lsu_stall),    32'd0);

    // Misaligned LW and illegal SW width
    issue(OP_LD, 3'b010, 5'd2, 32'h102, 32'd0);
    check("mis_exc",  32'(exc),          32'd1);
    check("mis_code", 32'(exc_code),     32'd1);
    check("mis_req",  32'(dmem_bus.req), 32'd0);
    check("mis_stall",32'(lsu_stall),    32'd0);
    check("mis_wbv",  32'(wb_valid),     32'd0);
    issue(OP_ST, 3'b011, 5'd2, 32'h100, 32'd0);
    check("ill_exc",  32'(exc),          32'd1);
    check("ill_code", 32'(exc_code),     32'd2);
    check("ill_req",  32'(dmem_bus.req), 32'd0);
    tick();
    check("ill_pulse",32'(exc),          32'd0);

    // Timeout: gnt, rvalid never; REQ+WAIT cycles 1..16, exc afterwards
    issue(OP_LD, 3'b010, 5'd5, 32'h200, 32'd0);
    dmem_bus.gnt = 1'b1; tick(); dmem_bus.gnt = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("to_wait_stall", 32'(lsu_stall), 32'd1);
      check("to_wait_exc",   32'(exc),       32'd0);
      tick();
    end
    check("to_last_stall", 32'(lsu_stall),   32'd1);
    tick();
    check("to_exc",   32'(exc),          32'd1);
    check("to_code",  32'(exc_code),     32'd3);
    check("to_stall", 32'(lsu_stall),    32'd0);
    check("to_wbv",   32'(wb_valid),     32'd0);
    tick();

    // Reset asserted while waiting for rvalid
    issue(OP_LD, 3'b010, 5'd6, 32'h300, 32'd0);
    dmem_bus.gnt = 1'b1; tick(); dmem_bus.gnt = 1'b0;
    check("rw_stall_pre", 32'(lsu_stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rw_stall", 32'(lsu_stall),    32'd0);
    check("rw_req",   32'(dmem_bus.req), 32'd0);
    check("rw_wbv",   32'(wb_valid),     32'd0);
    tick();
    rst = 1'b0;
    dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h11111111;
    tick();
    dmem_bus.rvalid = 1'b0;
    check("rw_no_wb", 32'(wb_valid),     32'd0);
    check("rw_no_exc",32'(exc),          32'd0);

    // Reset asserted mid-REQ drops the request at once
    issue(OP_LD, 3'b010, 5'd6, 32'h300, 32'd0);
    check("rr_req_pre", 32'(dmem_bus.req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rr_req",   32'(dmem_bus.req), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
